// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: widths, opcodes,
// PC jump_control encodings and the FSM state encoding.
package pc_seq_pkg;

  localparam int ADDR_W      = 12;
  localparam int INSTR_W     = 16;
  localparam int LOOP_W      = 8;
  localparam int STACK_DEPTH = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JEQ  = 4'h2;
  localparam logic [3:0] OP_SETL = 4'h3;
  localparam logic [3:0] OP_LOOP = 4'h4;
  localparam logic [3:0] OP_HALT = 4'h5;
  localparam logic [3:0] OP_CALL = 4'h6;
  localparam logic [3:0] OP_RET  = 4'h7;

  typedef enum logic [1:0] {
    JC_INC  = 2'b00,
    JC_HOLD = 2'b01,
    JC_LDEQ = 2'b10,
    JC_LD   = 2'b11
  } jc_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_HALT
  } state_e;

  // Opcodes 8..F are handed to the datapath.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO for CALL/RET; only compiled when CALL_STACK_EN is
// defined, so the default build carries no stack storage.
`ifdef CALL_STACK_EN
module pc_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[PW'(count - 1'b1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  // NOTE: the entry array has no reset; count alone decides which entries are
  // meaningful, and leaving the array unreset lets it map to plain storage.
  always_ff @(posedge clk) begin
    if (push && !full) mem[count[PW-1:0]] <= din;
  end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM driving the 12-bit program counter.
// Define CALL_STACK_EN to build CALL/RET with a return stack.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               imem_req,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ex_start,
  output logic [3:0]         ex_op,
  output logic [11:0]        ex_operand,
  input  logic               ex_done,
  output logic [1:0]         pc_jump_control,
  output logic [ADDR_W-1:0]  pc_load_data,
  output logic               pc_roll_over,
  output logic               busy,
  output logic               halted,
  output logic               illegal_op
);

  state_e              state, state_nxt;
  logic [INSTR_W-1:0]  instr;
  logic [LOOP_W-1:0]   loop_cnt, loop_nxt;
  logic [3:0]          op;
  logic [ADDR_W-1:0]   operand;
  logic                illegal_set;
  jc_e                 jc;

  assign op         = instr[15:12];
  assign operand    = instr[ADDR_W-1:0];
  assign ex_op      = op;
  assign ex_operand = operand;
  assign imem_req   = (state == S_FETCH);
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);
  assign pc_jump_control = jc;

`ifdef CALL_STACK_EN
  logic              push, pop, stack_full, stack_empty;
  logic [ADDR_W-1:0] stack_top;

  pc_return_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_addr + ADDR_W'(1)),
    .dout  (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );
`else
  logic unused_pc_addr;
  assign unused_pc_addr = ^pc_addr;
`endif

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt    = state;
    jc           = JC_HOLD;
    pc_load_data = '0;
    pc_roll_over = 1'b0;
    loop_nxt     = loop_cnt;
    illegal_set  = 1'b0;
`ifdef CALL_STACK_EN
    push = 1'b0;
    pop  = 1'b0;
`endif
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_roll_over = 1'b1;
          jc           = JC_INC;
          state_nxt    = S_FETCH;
        end
      end
      S_FETCH:  if (imem_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = is_alu_op(op) ? S_EXEC : S_UPDATE;
      S_EXEC:   if (ex_done) state_nxt = S_UPDATE;
      S_UPDATE: begin
        state_nxt = S_FETCH;
        jc        = JC_INC;
        case (op)
          OP_JMP: begin jc = JC_LD;   pc_load_data = operand; end
          OP_JEQ: begin jc = JC_LDEQ; pc_load_data = operand; end
          OP_SETL: loop_nxt = operand[LOOP_W-1:0];
          OP_LOOP: begin
            if (loop_cnt != '0) begin
              loop_nxt     = loop_cnt - 1'b1;
              jc           = JC_LD;
              pc_load_data = operand;
            end
          end
          OP_HALT: begin jc = JC_HOLD; state_nxt = S_HALT; end
`ifdef CALL_STACK_EN
          OP_CALL: begin
            if (stack_full) illegal_set = 1'b1;
            else begin push = 1'b1; jc = JC_LD; pc_load_data = operand; end
          end
          OP_RET: begin
            if (stack_empty) illegal_set = 1'b1;
            else begin pop = 1'b1; jc = JC_LD; pc_load_data = stack_top; end
          end
`else
          OP_CALL, OP_RET: illegal_set = 1'b1;
`endif
          default: ;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      instr      <= '0;
      loop_cnt   <= '0;
      ex_start   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state    <= state_nxt;
      loop_cnt <= loop_nxt;
      ex_start <= (state == S_DECODE) && is_alu_op(op);
      if (state == S_FETCH && imem_valid) instr <= imem_rdata;
      illegal_op <= pc_roll_over ? 1'b0 : (illegal_op | illegal_set);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer (default build): a
// per-instruction reference model predicts every cycle's control outputs.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, imem_valid, ex_done;
  logic [11:0] pc_addr;
  logic [15:0] imem_rdata;
  logic        imem_req, ex_start, pc_roll_over, busy, halted, illegal_op;
  logic [3:0]  ex_op;
  logic [11:0] ex_operand, pc_load_data;
  logic [1:0]  pc_jump_control;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pc_addr(pc_addr),
    .imem_req(imem_req), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .ex_start(ex_start), .ex_op(ex_op), .ex_operand(ex_operand), .ex_done(ex_done),
    .pc_jump_control(pc_jump_control), .pc_load_data(pc_load_data),
    .pc_roll_over(pc_roll_over), .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: program counter, loop counter, sticky illegal flag.
  logic [11:0] pc_ref;
  int          loop_ref;
  bit          illegal_ref;

  assign pc_addr = pc_ref;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_jc"},      32'(pc_jump_control), 32'(JC_HOLD));
    check({tag, "_req"},     32'(imem_req), 32'd0);
    check({tag, "_exstart"}, 32'(ex_start), 32'd0);
    check({tag, "_exop"},    32'(ex_op), 32'd0);
    check({tag, "_exopnd"},  32'(ex_operand), 32'd0);
    check({tag, "_load"},    32'(pc_load_data), 32'd0);
    check({tag, "_roll"},    32'(pc_roll_over), 32'd0);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_halted"},  32'(halted), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_op), 32'd0);
  endtask

  // start from IDLE/HALT: one roll_over cycle, then fetching from address 0.
  task automatic do_start;
    start = 1'b1;
    settle;
    check("start_roll", 32'(pc_roll_over), 32'd1);
    check("start_busy", 32'(busy), 32'd0);
    tick;
    start       = 1'b0;
    pc_ref      = 12'h000;
    illegal_ref = 1'b0;
    settle;
    check("post_roll", 32'(pc_roll_over), 32'd0);
    check("post_busy", 32'(busy), 32'd1);
  endtask

  // Apply one instruction end to end. abort asserts rst two cycles into EXEC.
  task automatic run_instr(input logic [15:0] w, input int fdelay, input int xdelay,
                           input bit abort, output bit went_halt);
    logic [3:0]  op;
    logic [11:0] opr;
    logic [1:0]  exp_jc;
    bit          exp_halt;
    int          c;
    op        = w[15:12];
    opr       = w[11:0];
    went_halt = 1'b0;

    for (int i = 0; i < fdelay; i++) begin
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      start      = 1'($urandom_range(0, 1));
      settle;
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_jc", 32'(pc_jump_control), 32'(JC_HOLD));
      tick;
    end
    start      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = w;
    settle;
    check("fetch_req", 32'(imem_req), 32'd1);
    tick;

    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    settle;
    check("dec_req", 32'(imem_req), 32'd0);
    check("dec_jc", 32'(pc_jump_control), 32'(JC_HOLD));
    check("dec_exstart", 32'(ex_start), 32'd0);
    tick;

    if (op >= 4'd8) begin
      c = 0;
      do begin
        if (abort && c == 2) begin
          rst = 1'b1;
          settle;
          check_reset_outputs("abort");
          tick;
          rst        = 1'b0;
          ex_done    = 1'b0;
          imem_valid = 1'b0;
          for (int k = 0; k < 3; k++) begin
            settle;
            check_reset_outputs("after_abort");
            tick;
          end
          return;
        end
        ex_done    = (c == xdelay);
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = 16'($urandom);
        settle;
        check("ex_start", 32'(ex_start), (c == 0) ? 32'd1 : 32'd0);
        if (c == 0) begin
          check("ex_op", 32'(ex_op), 32'(op));
          check("ex_operand", 32'(ex_operand), 32'(opr));
        end
        check("exec_jc", 32'(pc_jump_control), 32'(JC_HOLD));
        tick;
        c++;
      end while (c <= xdelay);
      ex_done = 1'b0;
    end

    // UPDATE: expected action straight from the opcode table.
    exp_jc   = JC_INC;
    exp_halt = 1'b0;
    case (op)
      4'd1: exp_jc = JC_LD;
      4'd2: exp_jc = JC_LDEQ;
      4'd3: loop_ref = int'(opr[7:0]);
      4'd4: if (loop_ref > 0) begin loop_ref--; exp_jc = JC_LD; end
      4'd5: begin exp_jc = JC_HOLD; exp_halt = 1'b1; end
      4'd6, 4'd7: illegal_ref = 1'b1;
      default: ;
    endcase
    imem_valid = 1'b0;
    settle;
    check("upd_jc", 32'(pc_jump_control), 32'(exp_jc));
    if (exp_jc == JC_LD || exp_jc == JC_LDEQ)
      check("upd_load", 32'(pc_load_data), 32'(opr));
    check("upd_roll", 32'(pc_roll_over), 32'd0);
    check("upd_exstart", 32'(ex_start), 32'd0);
    tick;

    case (exp_jc)
      JC_INC:  pc_ref = pc_ref + 12'd1;
      JC_LD:   pc_ref = opr;
      JC_LDEQ: pc_ref = ($urandom_range(0, 1) != 0) ? opr : pc_ref + 12'd1;
      default: ;
    endcase
    settle;
    check("illegal", 32'(illegal_op), 32'(illegal_ref));
    check("halted", 32'(halted), 32'(exp_halt));
    check("busy", 32'(busy), exp_halt ? 32'd0 : 32'd1);
    went_halt = exp_halt;
  endtask

  initial begin
    bit h;
    logic [15:0] w;
    rst = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_rdata = '0; ex_done = 1'b0;
    pc_ref = '0; loop_ref = 0; illegal_ref = 1'b0;

    for (int i = 0; i < 2; i++) begin
      settle;
      check_reset_outputs("reset");
      tick;
    end
    rst = 1'b0;
    settle;
    check_reset_outputs("idle");
    do_start;

    run_instr(16'h102D, 3, 0, 1'b0, h);           // JMP 0x02D after a 3-cycle fetch wait
    run_instr(16'h2004, 0, 0, 1'b0, h);           // JEQ 0x004
    run_instr(16'h3003, 1, 0, 1'b0, h);           // SETL 3
    for (int i = 0; i < 4; i++) begin             // body + LOOP: 3 taken, 4th falls through
      run_instr(16'h0000, 0, 0, 1'b0, h);
      run_instr(16'h4010, 1, 0, 1'b0, h);
    end
    check("loop_end", 32'(loop_ref), 32'd0);
    run_instr(16'h3000, 0, 0, 1'b0, h);           // SETL 0 then LOOP falls straight through
    run_instr(16'h4123, 0, 0, 1'b0, h);
    run_instr(16'h90AB, 1, 5, 1'b0, h);           // ALU 9, ex_done after 5 cycles
    run_instr(16'hC321, 0, 0, 1'b0, h);           // ALU with ex_done alongside ex_start
    run_instr(16'h6123, 0, 0, 1'b0, h);           // CALL without the stack: illegal
    run_instr(16'h5000, 2, 0, 1'b0, h);           // HALT
    for (int i = 0; i < 3; i++) begin
      tick;
      check("hold_halted", 32'(halted), 32'd1);
      check("hold_jc", 32'(pc_jump_control), 32'(JC_HOLD));
    end
    do_start;

    for (int n = 0; n < 200; n++) begin
      w = 16'($urandom);
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0, h);
      if (h) begin
        repeat ($urandom_range(1, 3)) tick;
        do_start;
      end
    end

    run_instr(16'hA055, 0, 4, 1'b1, h);           // reset lands mid-EXEC
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
